// File: rtl/fht_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// fht_seq_ctrl_if
// Bundle between the FHT control sequencer, the start/ready handshake
// and the bank RAMs / butterfly datapath.
//   master : the sequencer. It receives start/log_size (and abort when
//            FHT_SEQ_ABORT_EN is defined). It drives the bank
//            addresses, write enables, source select, stage flags and rdy.
//   slave  : the host / memory side, which has the opposite directions.
// Optional macro: FHT_SEQ_ABORT_EN adds the abort request line.
// ----------------------------------------------------------------------------
interface fht_seq_ctrl_if #(
    parameter int A_BIT = 8,
    parameter int S_BIT = 4
);
    logic             start;
    logic [S_BIT-1:0] log_size;
`ifdef FHT_SEQ_ABORT_EN
    logic             abort;
`endif
    logic [A_BIT-1:0] addr_rd_0;
    logic [A_BIT-1:0] addr_rd_1;
    logic [A_BIT-1:0] addr_rd_2;
    logic [A_BIT-1:0] addr_rd_3;
    logic [A_BIT-1:0] addr_wr_0;
    logic [A_BIT-1:0] addr_wr_1;
    logic [A_BIT-1:0] addr_wr_2;
    logic [A_BIT-1:0] addr_wr_3;
    logic [A_BIT-1:0] addr_coef;
    logic             we_a;
    logic             we_b;
    logic             source_data;
    logic [S_BIT-1:0] stage;
    logic             st_zero;
    logic             st_last;
    logic             rdy;

`ifdef FHT_SEQ_ABORT_EN
    modport master (
        input  start, log_size, abort,
        output addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3,
               addr_wr_0, addr_wr_1, addr_wr_2, addr_wr_3,
               addr_coef, we_a, we_b, source_data, stage, st_zero, st_last, rdy
    );
    modport slave (
        output start, log_size, abort,
        input  addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3,
               addr_wr_0, addr_wr_1, addr_wr_2, addr_wr_3,
               addr_coef, we_a, we_b, source_data, stage, st_zero, st_last, rdy
    );
`else
    modport master (
        input  start, log_size,
        output addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3,
               addr_wr_0, addr_wr_1, addr_wr_2, addr_wr_3,
               addr_coef, we_a, we_b, source_data, stage, st_zero, st_last, rdy
    );
    modport slave (
        output start, log_size,
        input  addr_rd_0, addr_rd_1, addr_rd_2, addr_rd_3,
               addr_wr_0, addr_wr_1, addr_wr_2, addr_wr_3,
               addr_coef, we_a, we_b, source_data, stage, st_zero, st_last, rdy
    );
`endif
endinterface

// File: rtl/fht_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fht_seq_ctrl
// Variable-length FHT control sequencer for a 4-bank memory.
// The transform size is N = 4*2^L, with L latched from log_size at start
// and clamped to the range [2, A_BIT].
// The block runs L+2 stages. Each stage lasts 2^L + RD_WR_LAT cycles:
// 2^L read cycles, and then write cycles. The writes replay the read
// addresses RD_WR_LAT cycles later.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fht_seq_ctrl_if.master. It carries the start handshake,
//              the bank read/write addresses, the coefficient address,
//              the ping-pong write enables, the source select and the
//              stage flags.
// Optional macro: FHT_SEQ_ABORT_EN adds bus.abort. An abort request
// returns the block to idle on the next edge and drops all pending writes.
// ----------------------------------------------------------------------------
module fht_seq_ctrl #(
    parameter int A_BIT     = 8,
    parameter int RD_WR_LAT = 4,
    parameter int S_BIT     = 4
) (
    input  logic           clk,
    input  logic           rst,
    fht_seq_ctrl_if.master bus
);
    // Cycle-in-stage counter must reach 2^A_BIT + RD_WR_LAT - 1.
    localparam int CW = $clog2((1 << A_BIT) + RD_WR_LAT);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_r, state_nxt_s;
    logic [S_BIT-1:0] l_r, l_nxt_s;
    logic [S_BIT-1:0] stage_r, stage_nxt_s;
    logic [CW-1:0]    cyc_r, cyc_nxt_s;
    logic [CW-1:0]    stage_end_s;
    logic             abort_s, start_ok_s, flush_s;
    logic             run_nxt_s, rd_vld_nxt_s;
    logic [A_BIT-1:0] addr_nxt_s, coef_nxt_s;

    logic [A_BIT-1:0] addr_rd_r, addr_wr_r, coef_r;
    logic [S_BIT-1:0] stage_o_r;
    logic             we_a_r, we_b_r, src_r, st_zero_r, st_last_r, rdy_r;

    // Read-valid delay line. The write address and the stage parity ride alongside it.
    logic             pv_r [RD_WR_LAT];
    logic [A_BIT-1:0] pa_r [RD_WR_LAT];
    logic             pp_r [RD_WR_LAT];

`ifdef FHT_SEQ_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif
    assign start_ok_s  = bus.start & ~abort_s;
    assign flush_s     = abort_s & (state_r == ST_RUN);
    assign stage_end_s = (CW'(1) << l_r) + CW'(RD_WR_LAT - 1);

    function automatic logic [S_BIT-1:0] clamp_l(input logic [S_BIT-1:0] v);
        logic [S_BIT-1:0] r;
        if (v < S_BIT'(2)) begin
            r = S_BIT'(2);
        end else if (v > S_BIT'(A_BIT)) begin
            r = S_BIT'(A_BIT);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Bank read address for stage s, size L, and read index c (where c < 2^L).
    function automatic logic [A_BIT-1:0] rd_addr_f(input logic [S_BIT-1:0] s,
                                                   input logic [S_BIT-1:0] l,
                                                   input logic [A_BIT-1:0] c);
        logic [A_BIT-1:0] rev;
        logic [A_BIT-1:0] mask;
        logic [A_BIT-1:0] r;
        // Reverse all A_BIT bits, then shift down. This leaves the L-bit
        // reversal, because the upper bits of c are zero.
        for (int i = 0; i < A_BIT; i++) begin
            rev[i] = c[A_BIT-1-i];
        end
        mask = (A_BIT'(1) << l) - A_BIT'(1);
        if (s == {S_BIT{1'b0}}) begin
            r = rev >> (A_BIT - int'(l));
        end else if (s < l) begin
            r = ((c << s) | (c >> (l - s))) & mask;
        end else begin
            r = c;
        end
        return r;
    endfunction

    // Twiddle ROM address. The result is computed in A_BIT bits and truncated.
    function automatic logic [A_BIT-1:0] coef_f(input logic [S_BIT-1:0] s,
                                                input logic [S_BIT-1:0] l,
                                                input logic [A_BIT-1:0] c);
        logic [A_BIT-1:0] k;
        if (s == {S_BIT{1'b0}}) begin
            k = {A_BIT{1'b0}};
        end else if (s < l) begin
            k = (c & ((A_BIT'(1) << s) - A_BIT'(1))) << (A_BIT - 1 - int'(s));
        end else if (s == l) begin
            k = (c << (A_BIT - int'(l))) >> 1;
        end else begin
            k = c << (A_BIT - int'(l));
        end
        return k;
    endfunction

    // State and sequencing counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            l_r     <= S_BIT'(2);
            stage_r <= {S_BIT{1'b0}};
            cyc_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            l_r     <= l_nxt_s;
            stage_r <= stage_nxt_s;
            cyc_r   <= cyc_nxt_s;
        end
    end

    // Next-state logic: start latch, stage advance, and the end of the run or an abort
    always_comb begin
        state_nxt_s = state_r;
        l_nxt_s     = l_r;
        stage_nxt_s = stage_r;
        cyc_nxt_s   = cyc_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_RUN;
                    l_nxt_s     = clamp_l(bus.log_size);
                    stage_nxt_s = {S_BIT{1'b0}};
                    cyc_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cyc_r == stage_end_s) begin
                    cyc_nxt_s = {CW{1'b0}};
                    if (stage_r == l_r + S_BIT'(1)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        stage_nxt_s = stage_r + S_BIT'(1);
                    end
                end else begin
                    cyc_nxt_s = cyc_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next-cycle output values, derived from the next state so that every output is a flop
    always_comb begin
        run_nxt_s    = (state_nxt_s == ST_RUN);
        rd_vld_nxt_s = 1'b0;
        addr_nxt_s   = addr_rd_r;
        coef_nxt_s   = coef_r;
        if (run_nxt_s && (cyc_nxt_s < (CW'(1) << l_nxt_s))) begin
            rd_vld_nxt_s = 1'b1;
            addr_nxt_s   = rd_addr_f(stage_nxt_s, l_nxt_s, cyc_nxt_s[A_BIT-1:0]);
            coef_nxt_s   = coef_f(stage_nxt_s, l_nxt_s, cyc_nxt_s[A_BIT-1:0]);
        end else begin
            rd_vld_nxt_s = 1'b0;
        end
    end

    // Read-to-write delay line; an abort empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_WR_LAT; i++) begin
                pv_r[i] <= 1'b0;
                pa_r[i] <= {A_BIT{1'b0}};
                pp_r[i] <= 1'b0;
            end
        end else begin
            pv_r[0] <= rd_vld_nxt_s & ~flush_s;
            pa_r[0] <= addr_nxt_s;
            pp_r[0] <= stage_nxt_s[0];
            for (int i = 1; i < RD_WR_LAT; i++) begin
                pv_r[i] <= pv_r[i-1] & ~flush_s;
                pa_r[i] <= pa_r[i-1];
                pp_r[i] <= pp_r[i-1];
            end
        end
    end

    // Output registers. Addresses hold their value between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_r     <= 1'b1;
            addr_rd_r <= {A_BIT{1'b0}};
            addr_wr_r <= {A_BIT{1'b0}};
            coef_r    <= {A_BIT{1'b0}};
            stage_o_r <= {S_BIT{1'b0}};
            st_zero_r <= 1'b0;
            st_last_r <= 1'b0;
            src_r     <= 1'b0;
            we_a_r    <= 1'b0;
            we_b_r    <= 1'b0;
        end else begin
            rdy_r     <= ~run_nxt_s;
            addr_rd_r <= addr_nxt_s;
            coef_r    <= coef_nxt_s;
            stage_o_r <= run_nxt_s ? stage_nxt_s : {S_BIT{1'b0}};
            st_zero_r <= run_nxt_s & (stage_nxt_s == {S_BIT{1'b0}});
            st_last_r <= run_nxt_s & (stage_nxt_s == l_nxt_s + S_BIT'(1));
            src_r     <= run_nxt_s & stage_nxt_s[0];
            // Odd stages write bank set A, and even stages write bank set B.
            we_a_r    <= pv_r[RD_WR_LAT-1] &  pp_r[RD_WR_LAT-1] & ~flush_s;
            we_b_r    <= pv_r[RD_WR_LAT-1] & ~pp_r[RD_WR_LAT-1] & ~flush_s;
            if (pv_r[RD_WR_LAT-1] && !flush_s) begin
                addr_wr_r <= pa_r[RD_WR_LAT-1];
            end else begin
                addr_wr_r <= addr_wr_r;
            end
        end
    end

    assign bus.addr_rd_0   = addr_rd_r;
    assign bus.addr_rd_1   = addr_rd_r;
    assign bus.addr_rd_2   = addr_rd_r;
    assign bus.addr_rd_3   = addr_rd_r;
    assign bus.addr_wr_0   = addr_wr_r;
    assign bus.addr_wr_1   = addr_wr_r;
    assign bus.addr_wr_2   = addr_wr_r;
    assign bus.addr_wr_3   = addr_wr_r;
    assign bus.addr_coef   = coef_r;
    assign bus.we_a        = we_a_r;
    assign bus.we_b        = we_b_r;
    assign bus.source_data = src_r;
    assign bus.stage       = stage_o_r;
    assign bus.st_zero     = st_zero_r;
    assign bus.st_last     = st_last_r;
    assign bus.rdy         = rdy_r;
endmodule

// File: tb/tb_fht_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fht_seq_ctrl
// Self-checking bench for fht_seq_ctrl with A_BIT=8, RD_WR_LAT=4, S_BIT=4.
// A table of runs (log_size in, clamped L, busy length) is applied, along
// with a few randomized runs. Each cycle of a run is compared against a
// reference model. The model uses plain integer arithmetic on the
// stage/cycle timeline. Hand-written sequences cover the asynchronous
// reset in the middle of a run and the optional abort.
// ----------------------------------------------------------------------------
module tb_fht_seq_ctrl;
    localparam int A   = 8;
    localparam int LAT = 4;
    localparam int SB  = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   hist [0:3100];
    int   cap  [0:7];

    fht_seq_ctrl_if #(.A_BIT(A), .S_BIT(SB)) bus ();

    fht_seq_ctrl #(.A_BIT(A), .RD_WR_LAT(LAT), .S_BIT(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int log_in;
        int exp_l;
        int exp_busy;
        bit noisy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pw2(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 2;
        return r;
    endfunction

    // Model: read address of index c at stage s for size L
    function automatic int m_rd(input int s, input int l, input int c);
        int r;
        if (s == 0) begin
            r = 0;
            for (int i = 0; i < l; i++) r = r * 2 + ((c / pw2(i)) % 2);
        end else if (s < l) begin
            r = (c * pw2(s)) % pw2(l) + c / pw2(l - s);
        end else begin
            r = c;
        end
        return r;
    endfunction

    // Model: coefficient address (8 bits, truncated)
    function automatic int m_coef(input int s, input int l, input int c);
        if (s == 0) return 0;
        else if (s < l) return ((c % pw2(s)) * pw2(A - s - 1)) % 256;
        else if (s == l) return ((c * pw2(A - l)) % 256) / 2;
        else return (c * pw2(A - l)) % 256;
    endfunction

    task automatic do_run(input int log_in, input int exp_l, input int exp_busy, input bit noisy);
        int d, len, s, j, e, busy;
        d    = pw2(exp_l);
        len  = d + LAT;
        busy = -1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.log_size = 4'(log_in);
        for (int t = 1; t <= 3000; t++) begin
            @(negedge clk);
            if (bus.rdy === 1'b1) begin
                busy = t - 1;
                break;
            end
            if (t <= exp_busy) begin
                s = (t - 1) / len;
                j = (t - 1) % len;
                chk("stage", 32'(bus.stage), 32'(s));
                chk("st_zero", 32'(bus.st_zero), 32'(s == 0));
                chk("st_last", 32'(bus.st_last), 32'(s == exp_l + 1));
                chk("source", 32'(bus.source_data), 32'(s % 2));
                chk("we_a", 32'(bus.we_a), 32'(j >= LAT && j < LAT + d && s % 2 == 1));
                chk("we_b", 32'(bus.we_b), 32'(j >= LAT && j < LAT + d && s % 2 == 0));
                if (j < d) begin
                    e = m_rd(s, exp_l, j);
                    hist[t] = e;
                    chk("addr_rd_0", 32'(bus.addr_rd_0), 32'(e));
                    chk("addr_rd_1", 32'(bus.addr_rd_1), 32'(e));
                    chk("addr_rd_2", 32'(bus.addr_rd_2), 32'(e));
                    chk("addr_rd_3", 32'(bus.addr_rd_3), 32'(e));
                    chk("addr_coef", 32'(bus.addr_coef), 32'(m_coef(s, exp_l, j)));
                    if (exp_l == 3 && s == 2) cap[j] = int'(bus.addr_coef);
                end
                if (j >= LAT && j < LAT + d) begin
                    chk("addr_wr_0", 32'(bus.addr_wr_0), 32'(hist[t - LAT]));
                    chk("addr_wr_1", 32'(bus.addr_wr_1), 32'(hist[t - LAT]));
                    chk("addr_wr_2", 32'(bus.addr_wr_2), 32'(hist[t - LAT]));
                    chk("addr_wr_3", 32'(bus.addr_wr_3), 32'(hist[t - LAT]));
                end
            end
            // Start pulses and log_size changes during the run must be ignored.
            if (noisy && t < exp_busy) begin
                bus.start    = ($urandom_range(0, 5) == 0);
                bus.log_size = 4'($urandom_range(0, 15));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("busy_len", 32'(busy), 32'(exp_busy));
        if (busy == exp_busy) begin
            // At the first idle cycle, writes are off and addresses hold their last value.
            chk("idle_we_a", 32'(bus.we_a), 32'd0);
            chk("idle_we_b", 32'(bus.we_b), 32'd0);
            chk("idle_addr_rd", 32'(bus.addr_rd_0), 32'(d - 1));
            chk("idle_addr_wr", 32'(bus.addr_wr_0), 32'(d - 1));
            chk("idle_coef", 32'(bus.addr_coef), 32'(m_coef(exp_l + 1, exp_l, d - 1)));
        end
    endtask

    vec_t vecs [7];
    int   coef_ref [8];

    initial begin
        int v, l;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 8; i++) cap[i] = -1;
        coef_ref = '{0, 32, 64, 96, 0, 32, 64, 96};
        vecs[0] = '{2, 2, 32, 1'b0};
        vecs[1] = '{0, 2, 32, 1'b0};
        vecs[2] = '{1, 2, 32, 1'b1};
        vecs[3] = '{3, 3, 60, 1'b0};
        vecs[4] = '{4, 4, 120, 1'b1};
        vecs[5] = '{12, 8, 2600, 1'b1};
        vecs[6] = '{5, 5, 252, 1'b0};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.log_size = 4'd0;
`ifdef FHT_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(bus.rdy), 32'd1);
        chk("rst_we_a", 32'(bus.we_a), 32'd0);
        chk("rst_we_b", 32'(bus.we_b), 32'd0);
        chk("rst_src", 32'(bus.source_data), 32'd0);
        chk("rst_stage", 32'(bus.stage), 32'd0);
        chk("rst_st_zero", 32'(bus.st_zero), 32'd0);
        chk("rst_st_last", 32'(bus.st_last), 32'd0);
        chk("rst_addr_rd", 32'(bus.addr_rd_0), 32'd0);
        chk("rst_addr_wr", 32'(bus.addr_wr_0), 32'd0);
        chk("rst_coef", 32'(bus.addr_coef), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            do_run(vecs[k].log_in, vecs[k].exp_l, vecs[k].exp_busy, vecs[k].noisy);
        end
        for (int i = 0; i < 8; i++) chk("coef_l3_s2", 32'(cap[i]), 32'(coef_ref[i]));

        // Asynchronous reset during the stage 2 write tail (L=2, cycle 21)
        @(negedge clk);
        bus.start    = 1'b1;
        bus.log_size = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_we_b", 32'(bus.we_b), 32'd1);
        chk("pre_rst_addr_rd", 32'(bus.addr_rd_0), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst_rdy", 32'(bus.rdy), 32'd1);
        chk("arst_we_a", 32'(bus.we_a), 32'd0);
        chk("arst_we_b", 32'(bus.we_b), 32'd0);
        chk("arst_addr_rd", 32'(bus.addr_rd_0), 32'd0);
        chk("arst_addr_wr", 32'(bus.addr_wr_0), 32'd0);
        chk("arst_stage", 32'(bus.stage), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_run(2, 2, 32, 1'b0);

`ifdef FHT_SEQ_ABORT_EN
        // Abort during stage 1 reads; writes already in the pipe must be dropped.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.log_size = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_rdy", 32'(bus.rdy), 32'd1);
        chk("abort_we_a", 32'(bus.we_a), 32'd0);
        chk("abort_we_b", 32'(bus.we_b), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_abort_we", 32'(bus.we_a | bus.we_b), 32'd0);
            chk("post_abort_rdy", 32'(bus.rdy), 32'd1);
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("abort_start_idle", 32'(bus.rdy), 32'd1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        do_run(2, 2, 32, 1'b0);
`endif

        // Randomized sizes, with noisy start and log_size during each run
        for (int k = 0; k < 3; k++) begin
            v = $urandom_range(0, 15);
            l = (v < 2) ? 2 : ((v > A) ? A : v);
            do_run(v, l, (l + 2) * (pw2(l) + LAT), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fht_seq_ctrl.md
Name: fht_seq_ctrl

Overview:
- Parametrised, variable-length successor to the FHT control sequencer.
- Generates per-stage read, write and coefficient addresses for the 4-bank FHT memory. Also drives ping-pong write enables, the data-source select and stage flags.
- Transform size is chosen at run time via iLOG_SIZE, so the block supports N = 4*2^L points for any L in [2, A_BIT].
- Sits between the top-level start/ready handshake and the bank RAMs / butterfly datapath.

Parameters:
- A_BIT, 8: bank address width; maximum bank depth is 2^A_BIT.
- RD_WR_LAT, 4: cycles from a read address to the write address of the same word (butterfly pipeline depth); must be ≥1.
- S_BIT, 4: stage counter width; must satisfy 2^S_BIT ≥ A_BIT+2.

Ports:
- iCLK, in, 1: clock.
- iRESET, in, 1: asynchronous reset, active-high.
- iSTART, in, 1: start pulse, sampled while idle.
- iLOG_SIZE, in, S_BIT: L = log2 of the active bank depth; latched at start.
- oADDR_RD_0..oADDR_RD_3, out, A_BIT each: bank read addresses.
- oADDR_WR_0..oADDR_WR_3, out, A_BIT each: bank write addresses.
- oADDR_COEF, out, A_BIT: twiddle ROM address.
- oWE_A, out, 1: write enable, bank set A.
- oWE_B, out, 1: write enable, bank set B.
- oSOURCE_DATA, out, 1: read bank set; 0 = A, 1 = B.
- oSTAGE, out, S_BIT: current stage index.
- oST_ZERO, out, 1: high during stage 0.
- oST_LAST, out, 1: high during stage L+1.
- oRDY, out, 1: high when idle.

Behaviour:
- Reset values: oRDY=1; all other outputs 0. Reset mid-run aborts immediately with no pending writes.
- States:
  - IDLE → RUN on a rising edge with iSTART=1. At that edge: L is latched (clamped to 2 if <2, to A_BIT if >A_BIT); stage=0, cnt=0, wcnt=0; oRDY falls.
  - iSTART is ignored in RUN.
- Let D = 2^L. Each stage has a read phase and a write phase.
  - Read phase: cnt runs 0..D-1, one address per cycle; the read-valid flag is high.
  - After the read phase, a read-valid delay line of RD_WR_LAT stages, with write addresses riding alongside, produces D write cycles.
  - Stage length = D + RD_WR_LAT cycles. The next stage's first read occurs the cycle after the previous stage's last write; there is no read/write overlap across stages.
- Read addresses: all four banks receive the same address. Indexing uses L bits, zero-extended to A_BIT.
  - Stage 0: bit-reverse of cnt over L bits.
  - Stages 1..L-1: cnt rotated left by s over L bits.
  - Stages L and L+1 (cross-bank): cnt.
- Write addresses equal the read addresses delayed exactly RD_WR_LAT cycles, all four banks.
- oWE_B is high on write cycles of even stages; oWE_A is high on write cycles of odd stages. Never both high.
- oSOURCE_DATA = stage[0] (even stages read A, odd read B). It is held constant across the whole stage, including the write tail.
- oADDR_COEF is valid with the read address; computed in A_BIT bits, truncated.
  - Stage 0: 0.
  - Stage s in 1..L-1: (cnt & (2^s−1)) << (A_BIT−s−1).
  - Stage L: (cnt << (A_BIT−L)) >> 1.
  - Stage L+1: cnt << (A_BIT−L).
- oSTAGE increments on the edge after the last write of a stage.
- After the last write of stage L+1: return to IDLE, oRDY=1 on the next edge. All addresses hold their last values; WE=0.
- Total busy time = (L+2)·(D+RD_WR_LAT) cycles.

Optional Feature:
- Macro: FHT_SEQ_ABORT_EN.
- Defined: adds input port iABORT (1 bit).
  - iABORT=1 in RUN forces IDLE on the next edge: oRDY=1, WE=0, delay line cleared.
  - iABORT has priority over stage advance.
  - iABORT and iSTART both high in IDLE: stay IDLE.
- Undefined: the port is absent and the run always completes.

Test Plan:
- Reset: iRESET=1 mid-run at stage 2 → oRDY=1, oWE_A=oWE_B=0 and all addresses 0 immediately (asynchronous).
- L=2, RD_WR_LAT=4, start:
  - oRDY low for exactly 32 cycles.
  - Stage 0 read addresses 0,2,1,3.
  - Stage 1 read addresses 0,2,1,3 (rotl1 over 2 bits).
  - Stages 2 and 3 read 0,1,2,3.
  - oST_LAST high only in stage 3.
- Same run: each write address equals the read address 4 cycles earlier. oWE_B high in cycles 5–8 and 21–24 after start; oWE_A high in cycles 13–16 and 29–32.
- A_BIT=8, L=3, stage 2: oADDR_COEF over cnt 0..7 = 0,32,64,96,0,32,64,96.
- iLOG_SIZE=12 with A_BIT=8 → clamped to L=8: busy (8+2)·(256+4)=2600 cycles. iSTART pulses during the run have no effect.
- FHT_SEQ_ABORT_EN: iABORT in stage 1 → oRDY=1 next edge, no further WE. A subsequent start with L=2 completes normally in 32 cycles.
